// File: rtl/tile_4_pic_fetch.sv
// Fetches palette indices for a 2x2 block of 32x32 tiles placed on the VGA
// raster. The tile map is double-buffered: writes land in a shadow copy that
// becomes active at the first pixel of each frame. Pixel path is two stages.
module tile_4_pic_fetch #(
  parameter logic [9:0] ORIGIN_X = 10'd256,
  parameter logic [9:0] ORIGIN_Y = 10'd176
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pix_valid_in,
  output logic [11:0] rom_addr,
  input  logic [4:0]  rom_q,
  input  logic        map_we,
  input  logic [1:0]  map_sel,
  input  logic [1:0]  map_tile,
  output logic [4:0]  index,
  output logic        pix_valid_out,
  output logic        in_tile
);

  localparam logic [3:0][1:0] IDENTITY_MAP = {2'd3, 2'd2, 2'd1, 2'd0};

  logic            in_region;
  logic [5:0]      lx;
  logic [5:0]      ly;
  logic [1:0]      slot;
  logic            commit;

  logic [3:0][1:0] shadow_map_q, shadow_map_d;
  logic [3:0][1:0] active_map_q, active_map_d;
  logic            hit_s1_q, hit_s1_d;
  logic            valid_s1_q, valid_s1_d;
  logic [4:0]      index_q, index_d;
  logic            in_tile_q, in_tile_d;
  logic            pix_valid_out_q, pix_valid_out_d;

  // Region test and ROM address; 11-bit compares keep ORIGIN+64 from wrapping.
  always_comb begin
    in_region = ({1'b0, DrawX} >= {1'b0, ORIGIN_X}) &&
                ({1'b0, DrawX} <  ({1'b0, ORIGIN_X} + 11'd64)) &&
                ({1'b0, DrawY} >= {1'b0, ORIGIN_Y}) &&
                ({1'b0, DrawY} <  ({1'b0, ORIGIN_Y} + 11'd64));
    lx       = DrawX[5:0] - ORIGIN_X[5:0];
    ly       = DrawY[5:0] - ORIGIN_Y[5:0];
    slot     = {ly[5], lx[5]};
    rom_addr = in_region ? {active_map_q[slot], ly[4:0], lx[4:0]} : '0;
  end

  // Map double buffer; commit reads the shadow value from before this cycle's write.
  always_comb begin
    commit       = pix_valid_in && (DrawX == '0) && (DrawY == '0);
    shadow_map_d = shadow_map_q;
    if (map_we) begin
      shadow_map_d[map_sel] = map_tile;
    end
    active_map_d = commit ? shadow_map_q : active_map_q;
  end

  // Next-state for the two pixel pipeline stages.
  always_comb begin
    hit_s1_d        = in_region && pix_valid_in;
    valid_s1_d      = pix_valid_in;
    index_d         = hit_s1_q ? rom_q : '0;
    in_tile_d       = hit_s1_q;
    pix_valid_out_d = valid_s1_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_map_q    <= IDENTITY_MAP;
      active_map_q    <= IDENTITY_MAP;
      hit_s1_q        <= 1'b0;
      valid_s1_q      <= 1'b0;
      index_q         <= '0;
      in_tile_q       <= 1'b0;
      pix_valid_out_q <= 1'b0;
    end else begin
      shadow_map_q    <= shadow_map_d;
      active_map_q    <= active_map_d;
      hit_s1_q        <= hit_s1_d;
      valid_s1_q      <= valid_s1_d;
      index_q         <= index_d;
      in_tile_q       <= in_tile_d;
      pix_valid_out_q <= pix_valid_out_d;
    end
  end

  assign index         = index_q;
  assign in_tile       = in_tile_q;
  assign pix_valid_out = pix_valid_out_q;

endmodule

// File: doc/tile_4_pic_fetch.md
TILE_4_PIC_FETCH -- requirements
Module: tile_4_pic_fetch

Interface
REQ-001 Parameter: ORIGIN_X, default 10'd256, left screen column of the 2x2 tile block.
REQ-002 Parameter: ORIGIN_Y, default 10'd176, top screen row of the 2x2 tile block.
REQ-003 Port: Clk  in  1  single clock for all state; rising edge.
REQ-004 Port: Reset  in  1  synchronous, active-high reset.
REQ-005 Port: DrawX  in  10  current pixel column from the VGA controller.
REQ-006 Port: DrawY  in  10  current pixel row from the VGA controller.
REQ-007 Port: pix_valid_in  in  1  DrawX/DrawY are an active-video pixel.
REQ-008 Port: rom_addr  out  12  tile-image ROM address, {tile_id[1:0], row[4:0], col[4:0]}.
REQ-009 Port: rom_q  in  5  ROM palette index; valid exactly one Clk after rom_addr.
REQ-010 Port: map_we  in  1  write strobe for the shadow tile map.
REQ-011 Port: map_sel  in  2  screen slot written: 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
REQ-012 Port: map_tile  in  2  tile id stored into slot map_sel.
REQ-013 Port: index  out  5  palette index driving the 32-entry palette lookup.
REQ-014 Port: pix_valid_out  out  1  pix_valid_in delayed to align with index.
REQ-015 Port: in_tile  out  1  index comes from the tile block, not background.

Function
REQ-016 The block SHALL occupy a 64x64 region: ORIGIN_X <= DrawX < ORIGIN_X+64 and ORIGIN_Y <= DrawY < ORIGIN_Y+64; compare with 11-bit arithmetic so ORIGIN+64 never wraps.
REQ-017 The block SHALL use local coords lx = DrawX-ORIGIN_X and ly = DrawY-ORIGIN_Y; slot = {ly[5], lx[5]}; row = ly[4:0]; col = lx[4:0].
REQ-018 rom_addr SHALL be combinational: {active_map[slot], row, col} when in region, else 12'd0.
REQ-019 Stage 1 SHALL register hit = in_region & pix_valid_in, together with pix_valid_in.
REQ-020 Stage 2 SHALL register index = hit_s1 ? rom_q : 5'd0, in_tile = hit_s1, and pix_valid_out = valid_s1.
REQ-021 Latency SHALL be exactly 2 Clk from DrawX/DrawY to index, with full throughput of one pixel per Clk and no stalls.
REQ-022 A cycle with map_we=1 SHALL write map_tile into shadow_map[map_sel]; writes are accepted every cycle with no busy signal.
REQ-023 Frame commit: a cycle with DrawX==0, DrawY==0 and pix_valid_in=1 SHALL copy shadow_map into active_map on that edge.
REQ-024 Address generation SHALL use active_map only, so no mid-frame tile change is visible.
REQ-025 Simultaneous map_we and frame commit: commit SHALL copy the pre-write shadow value; the new write lands in shadow and is committed at the next frame start.
REQ-026 Repeated writes to the same slot before a commit SHALL leave the last written value.
REQ-027 Out-of-region pixels and pix_valid_in=0 pixels SHALL produce index=0 and in_tile=0.

Reset
REQ-028 While Reset=1: index=0, in_tile=0, pix_valid_out=0, and both pipeline stages are cleared.
REQ-029 Reset SHALL load shadow_map and active_map to identity {slot0=0, slot1=1, slot2=2, slot3=3}.
REQ-030 Reset asserted mid-frame SHALL discard in-flight pixels; the first post-reset pixel appears 2 Clk after its inputs.

Verification
REQ-031 Pixel hit: Reset, then DrawX=256, DrawY=176, valid=1 -> rom_addr=12'h000 the same cycle; with rom_q=5'd7 next cycle, index=7, in_tile=1, pix_valid_out=1 two Clk after the input.
REQ-032 Slot decode: DrawX=256+33, DrawY=176+40 -> rom_addr={2'd3, 5'd8, 5'd1} = 12'hD01.
REQ-033 Edges: DrawX=255 or DrawX=320 (row inside) -> in_tile=0 and index=0 regardless of rom_q; DrawX=319 -> in_tile=1.
REQ-034 Double buffer: map_we with sel=0, tile=2 mid-frame -> slot-0 addresses keep tile 0 until the DrawX=0, DrawY=0 valid pixel; afterwards slot-0 addresses use prefix 2'd2.
REQ-035 Write and commit collide: map_we with sel=1, tile=0 on the commit cycle -> slot 1 still shows tile 1 for that frame and tile 0 after the next commit.
REQ-036 Streaming: continuous valid pixels across a full row -> one output per Clk and pix_valid_out is pix_valid_in delayed by exactly 2 Clk; Reset pulsed mid-row -> outputs 0 on the next edge.
